// File: rtl/lut_ram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_ram_sched_pkg
// Description : Shared types, constants and the round-robin pointer helper
//               for the lut_ram write-port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_ram_sched_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sched_state_t;

  localparam int MAX_WRITERS = 8;
  localparam int PTR_W       = $clog2(MAX_WRITERS);

  // (ptr+1) mod n, valid for ptr < n
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input int unsigned       n);
    logic [PTR_W:0] w_sum;
    w_sum = {1'b0, ptr} + (PTR_W+1)'(1);
    return (32'(w_sum) >= n) ? '0 : w_sum[PTR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_ram_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with a registered priority pointer; the
//               grant itself is purely combinational from req and pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import lut_ram_sched_pkg::*;
#(
  parameter int NUM_WRITERS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_WRITERS-1:0] req,
  output logic [NUM_WRITERS-1:0] grant
);

  logic [MAX_WRITERS-1:0] w_req_ext;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_next;
  logic [PTR_W-1:0]       w_win;
  logic [PTR_W:0]         w_idx;
  logic                   w_found;

  generate
    if (NUM_WRITERS < MAX_WRITERS) begin : g_pad_req
      assign w_req_ext = {{(MAX_WRITERS-NUM_WRITERS){1'b0}}, req};
    end else begin : g_full_req
      assign w_req_ext = req;
    end
  endgenerate

  // Walk from the pointer, wrapping at NUM_WRITERS; first requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_WRITERS)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_WRITERS);
      end
      if (!w_found && w_req_ext[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_WRITERS; j++) begin
      grant[j] = en && w_found && (w_win == PTR_W'(j));
    end
  end

  assign w_ptr_next = (en && w_found) ? rr_next(w_win, NUM_WRITERS) : r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lut_ram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lut_ram_write_scheduler
// Description : Round-robin sharing of the lut_ram write port with registered
//               write outputs; LUT_RAM_CLEAR_ON_RESET_EN adds a zeroing sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_ram_write_scheduler
  import lut_ram_sched_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int NUM_WRITERS = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_WRITERS-1:0]                      wr_req,
  input  logic [NUM_WRITERS-1:0][$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_WRITERS-1:0][WIDTH-1:0]           wr_data,
  output logic [NUM_WRITERS-1:0]                      wr_ack,
  output logic [$clog2(DEPTH)-1:0]                    waddr,
  output logic                                        ram_write,
  output logic [WIDTH-1:0]                            new_ram_data,
  output logic                                        init_done
);

  localparam int AW = $clog2(DEPTH);

  logic             w_run;
  logic             w_accept;
  logic [AW-1:0]    w_clr_addr;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .NUM_WRITERS (NUM_WRITERS)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_run),
    .req   (wr_req),
    .grant (wr_ack)
  );

`ifdef LUT_RAM_CLEAR_ON_RESET_EN
  sched_state_t  r_state;
  sched_state_t  w_state_next;
  logic [AW-1:0] r_clr_addr;
  logic          w_clr_last;

  assign w_clr_last = (r_clr_addr == AW'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + AW'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (w_clr_last) w_state_next = RUN;
      RUN:     w_state_next = RUN;
    endcase
  end

  assign w_run      = (r_state == RUN);
  assign w_clr_addr = r_clr_addr;
`else
  assign w_run      = 1'b1;
  assign w_clr_addr = '0;
`endif

  // Grant is one-hot, so an OR-style mux picks the winner's address/data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      if (wr_ack[i]) begin
        w_sel_addr = wr_addr[i];
        w_sel_data = wr_data[i];
      end
    end
  end

  assign w_accept = |wr_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write    <= 1'b0;
      waddr        <= '0;
      new_ram_data <= '0;
    end else if (!w_run) begin
      ram_write    <= 1'b1;
      waddr        <= w_clr_addr;
      new_ram_data <= '0;
    end else begin
      ram_write <= w_accept;
      if (w_accept) begin
        waddr        <= w_sel_addr;
        new_ram_data <= w_sel_data;
      end
    end
  end

  assign init_done = w_run;

endmodule
`default_nettype wire

// File: tb/tb_lut_ram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_ram_write_scheduler
// Description : Randomized self-checking bench with a queue-based reference
//               model of arbitration, clear sweep and RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_ram_write_scheduler;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NW    = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int D20   = 20;
  localparam int AW20  = $clog2(D20);
  localparam int QD    = 16;
`ifdef LUT_RAM_CLEAR_ON_RESET_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NW-1:0]              wr_req;
  logic [NW-1:0][AW-1:0]      wr_addr;
  logic [NW-1:0][WIDTH-1:0]   wr_data;
  logic [NW-1:0]              wr_ack;
  logic [AW-1:0]              waddr;
  logic                       ram_write;
  logic [WIDTH-1:0]           new_ram_data;
  logic                       init_done;

  logic [NW-1:0]              d20_req = '0;
  logic [NW-1:0][AW20-1:0]    d20_addr = '0;
  logic [NW-1:0][WIDTH-1:0]   d20_wdata = '0;
  logic [NW-1:0]              d20_ack;
  logic [AW20-1:0]            d20_waddr;
  logic                       d20_we;
  logic [WIDTH-1:0]           d20_data;
  logic                       d20_init;

  lut_ram_write_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WRITERS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .waddr(waddr), .ram_write(ram_write), .new_ram_data(new_ram_data),
    .init_done(init_done)
  );

  lut_ram_write_scheduler #(.WIDTH(WIDTH), .DEPTH(D20), .NUM_WRITERS(NW)) dut20 (
    .clk(clk), .rst_n(rst_n), .wr_req(d20_req), .wr_addr(d20_addr), .wr_data(d20_wdata),
    .wr_ack(d20_ack), .waddr(d20_waddr), .ram_write(d20_we), .new_ram_data(d20_data),
    .init_done(d20_init)
  );

  always #5 clk = ~clk;

  // Stand-in for the RAM array, fed only by the DUT write port.
  logic [WIDTH-1:0] dut_ram [DEPTH];
  always @(posedge clk) if (ram_write) dut_ram[waddr] <= new_ram_data;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               m_ptr, m_cnt, cyc;
  bit               m_in_clear;
  bit               exp_we;
  logic [AW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] model_ram   [DEPTH];
  bit               model_valid [DEPTH];
  logic [AW-1:0]    pend_addr   [NW][QD];
  logic [WIDTH-1:0] pend_data   [NW][QD];
  int               pend_n      [NW];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (pend_n[w] < QD) begin
      pend_addr[w][pend_n[w]] = a;
      pend_data[w][pend_n[w]] = d;
      pend_n[w]++;
    end
  endtask

  task automatic pop(input int w);
    for (int j = 0; j < pend_n[w] - 1; j++) begin
      pend_addr[w][j] = pend_addr[w][j+1];
      pend_data[w][j] = pend_data[w][j+1];
    end
    pend_n[w]--;
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int i = 0; i < NW; i++) if (pend_n[i] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NW; i++) begin
      wr_req[i]  = (pend_n[i] > 0);
      wr_addr[i] = (pend_n[i] > 0) ? pend_addr[i][0] : '0;
      wr_data[i] = (pend_n[i] > 0) ? pend_data[i][0] : '0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; cyc = 0; m_in_clear = CLEAR_EN;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    for (int i = 0; i < NW; i++) pend_n[i] = 0;
  endtask

  // Check this cycle's outputs, then advance the model by one clock.
  task automatic step();
    int            g;
    logic [NW-1:0] exp_ack;
    bit            exp20;
    check("ram_write", ram_write, exp_we);
    if (exp_we) begin
      check("waddr", waddr, exp_addr);
      check("new_ram_data", new_ram_data, exp_data);
    end
    check("init_done", init_done, !m_in_clear);
    exp20 = CLEAR_EN && cyc >= 1 && cyc <= D20;
    check("d20_ram_write", d20_we, exp20);
    if (exp20) check("d20_waddr", d20_waddr, cyc - 1);
    check("d20_init_done", d20_init, !CLEAR_EN || cyc >= D20);
    g = -1;
    if (!m_in_clear) begin
      for (int i = 0; i < NW; i++) begin
        int w = (m_ptr + i) % NW;
        if (g < 0 && pend_n[w] > 0) g = w;
      end
    end
    exp_ack = (g >= 0) ? NW'(1 << g) : '0;
    check("wr_ack", wr_ack, exp_ack);
    if (m_in_clear) begin
      exp_we = 1'b1; exp_addr = AW'(m_cnt); exp_data = '0;
      model_ram[m_cnt] = '0; model_valid[m_cnt] = 1'b1;
      if (m_cnt == DEPTH - 1) m_in_clear = 1'b0;
      else m_cnt++;
    end else if (g >= 0) begin
      exp_we = 1'b1; exp_addr = pend_addr[g][0]; exp_data = pend_data[g][0];
      model_ram[exp_addr] = exp_data; model_valid[exp_addr] = 1'b1;
      pop(g);
      m_ptr = (g + 1) % NW;
    end else begin
      exp_we = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_cycle(input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < NW; i++) begin
        if (pend_n[i] < 4 && $urandom_range(0, 99) < 45)
          push(i, $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH-1)),
               $urandom);
      end
    end
    drive_inputs();
    @(negedge clk);
    step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    #1;
    check("rst_ram_write", ram_write, 0);
    check("rst_waddr", waddr, 0);
    check("rst_new_ram_data", new_ram_data, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_init_done", init_done, !CLEAR_EN);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && any_pending(); k++) run_cycle(1'b0);
    check("drain_done", any_pending(), 0);
    run_cycle(1'b0);
    run_cycle(1'b0);
  endtask

  task automatic finish_sweep();
    for (int k = 0; k < DEPTH + 4 && m_in_clear; k++) run_cycle(1'b0);
    check("sweep_done", m_in_clear, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] single_data [5];
    for (int a = 0; a < DEPTH; a++) model_valid[a] = 1'b0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    apply_reset();

    // Reset part-way through the sweep, once clear address 12 is on the port.
    while (cyc <= 13) run_cycle(1'b0);
    #2;
    apply_reset();
    finish_sweep();

    // All four writers held busy: two writes each.
    for (int w = 0; w < NW; w++)
      for (int k = 0; k < 2; k++) push(w, AW'($urandom_range(0, DEPTH-1)), $urandom);
    drain();

    // Same-address conflict starting from pointer 0.
    push(0, AW'(7), 32'hAAAA);
    push(1, AW'(7), 32'h5555);
    drain();
    check("conflict_addr7", dut_ram[7], 32'h5555);

    // Lone requester 2 writing addresses 5..9 back to back.
    for (int k = 0; k < 5; k++) begin
      single_data[k] = $urandom;
      push(2, AW'(5 + k), single_data[k]);
    end
    drain();
    for (int k = 0; k < 5; k++) check("single_w2_entry", dut_ram[5 + k], single_data[k]);

    repeat (400) run_cycle(1'b1);
    drain();
    for (int a = 0; a < DEPTH; a++)
      if (model_valid[a]) check("ram_entry", dut_ram[a], model_ram[a]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lut_ram_write_scheduler.md
# lut_ram_write_scheduler

Shares the single write port of a `lut_ram` instance among `NUM_WRITERS` requesters using round-robin arbitration, and registers the winning write onto the RAM write port. It also sequences a post-reset clear sweep that writes zero to every entry, because the RAM array itself has no reset. The block sits directly in front of the RAM write port in register-file and tracking-table datapaths; the RAM read ports are not touched.

## Interface
- `WIDTH`, 32, data width of each RAM entry
- `DEPTH`, 32, number of entries; any value ≥ 2, power of two not required
- `NUM_WRITERS`, 4, number of write requesters; 1 to 8
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_req`  in  `[NUM_WRITERS]`  write request, one bit per requester
- `wr_addr`  in  `[NUM_WRITERS]` × `$clog2(DEPTH)`  per-requester write address
- `wr_data`  in  `[NUM_WRITERS]` × `WIDTH`  per-requester write data
- `wr_ack`  out  `[NUM_WRITERS]`  one-hot grant, combinational, same cycle as the accepted request
- `waddr`  out  `$clog2(DEPTH)`  registered RAM write address
- `ram_write`  out  1  registered RAM write enable
- `new_ram_data`  out  `WIDTH`  registered RAM write data
- `init_done`  out  1  high once the RAM contents are valid; stays high until the next reset

## Operation
- The state machine has two states, `CLEAR` and `RUN`. Reset enters `CLEAR` when the clear macro is defined, otherwise `RUN`.
- In `CLEAR`:
  - `wr_ack` is held at 0.
  - The clear counter steps from 0 to `DEPTH-1`, one entry per cycle, driving `ram_write=1` and `new_ram_data=0`.
  - After the cycle that issues address `DEPTH-1`, the state moves to `RUN` and `init_done` is set.
- In `RUN`, arbitration is round-robin:
  - The search starts at priority pointer `ptr` (reset value 0) and wraps modulo `NUM_WRITERS`.
  - The first requester found with `wr_req` high receives `wr_ack`.
  - `ptr` is then loaded with winner+1, wrapping modulo `NUM_WRITERS`. If there is no request, `ptr` holds its value.
- Handshake:
  - A write is accepted in the cycle where `wr_req && wr_ack` is true.
  - Requesters that are not granted must hold `wr_req`, `wr_addr` and `wr_data` stable until they are acknowledged.
  - `wr_ack` never depends on `wr_ack` or any output of the block, so there is no combinational loop.
- With exactly one active requester, that requester is granted every cycle.
- Simultaneous writes to the same address from different requesters are serialized in grant order, so the last-granted data wins.
- Reset asserted mid-operation: all registers clear asynchronously. The clear sweep, if compiled in, restarts from address 0, and any write that has been granted but not yet issued is dropped.

## Timing
- Reset values:
  - `ram_write`, `waddr` and `new_ram_data` are 0.
  - `wr_ack` is 0.
  - `init_done` is 0 with `LUT_RAM_CLEAR_ON_RESET_EN` defined, and 1 without it.
- A write accepted in cycle N appears on `ram_write`/`waddr`/`new_ram_data` in cycle N+1 and is stored in the RAM at the edge ending N+1. A read of that address returns the new data from cycle N+2.
- Throughput is one write per cycle, sustained.
- Clear sweep:
  - The first clear write is issued in the first cycle after `rst_n` deasserts.
  - `init_done` rises `DEPTH` cycles after reset release.
  - The first `wr_ack` is possible in the same cycle that `init_done` rises.
- Starvation bound: a held request is acknowledged within `NUM_WRITERS` cycles once the block is in `RUN`.

## Configuration
- The macro is `LUT_RAM_CLEAR_ON_RESET_EN`.
- Defined: the `CLEAR` state and the clear counter are present, and behaviour is as described above.
- Undefined:
  - No clear counter is built and the state machine is effectively always in `RUN`.
  - `init_done` is tied to 1.
  - RAM contents after reset are undefined.

## Structure
- Package `lut_ram_sched_pkg` holds:
  - the `sched_state_t` enum (`CLEAR`, `RUN`);
  - the `MAX_WRITERS = 8` constant;
  - the helper function `rr_next(ptr, n)`, which returns `(ptr+1) mod n`.
- Sub-module `rr_arbiter` takes `NUM_WRITERS` and the request vector and produces the one-hot grant and the next pointer. It is combinational apart from the pointer register.
- The top level holds the state machine, the clear counter and the write-port output registers.

## Test plan
- Clear sweep, `DEPTH=32`: release reset → addresses 0..31 written with 0 on 32 consecutive cycles, `init_done=1` from cycle 32, no `wr_ack` before that.
- Round-robin, 4 writers: after `init_done`, all `wr_req=4'b1111` held → grants in order 0,1,2,3,0, and RAM read after each write returns the granted `wr_data`.
- Single requester 2 with `wr_req` held for 5 cycles and addresses 5..9 → `wr_ack[2]=1` every cycle, and entries 5..9 hold their data from cycle N+2.
- Same-address conflict: writer 0 writes 0xAAAA and writer 1 writes 0x5555, both to address 7, with `ptr=0` → 0xAAAA written first, final read of address 7 returns 0x5555.
- Mid-sweep reset: assert `rst_n=0` at clear address 12 → outputs go to 0 immediately, and after release the sweep restarts at address 0 with `init_done=0`.
- Non-power-of-two `DEPTH=20` → the sweep ends at address 19, with no write to address 20 or above.
